// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store stage between the register file and a valid/ready data bus
// Stores read their data through the register-file memory port at accept; loads write back via a one-cycle strobe.
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [3:0]  req_reg,
  output logic [3:0]  memory_index,
  input  logic [15:0] memory_store,
  output logic [15:0] memory_load,
  output logic        memory_load_en,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  output logic        fault,
  input  logic        fault_clr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [3:0] lat_reg;
  logic [7:0] wait_cnt;
  logic       fault_set;

  // All status outputs decode from registered state, so bus_ready/bus_rdata never reach an output combinationally.
  assign req_ready      = (state == S_IDLE);
  assign memory_index   = req_ready ? req_reg : lat_reg;
  assign bus_valid      = (state == S_BUS);
  assign memory_load_en = (state == S_WB) && (lat_reg != 4'd0);
  assign fault_set      = bus_valid && !bus_ready && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lat_reg     <= 4'd0;
      wait_cnt    <= 8'd0;
      bus_write   <= 1'b0;
      bus_addr    <= 16'd0;
      bus_wdata   <= 16'd0;
      memory_load <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            bus_write <= req_write;
            bus_addr  <= req_addr;
            lat_reg   <= req_reg;
            bus_wdata <= memory_store;
            wait_cnt  <= 8'd0;
            state     <= S_BUS;
          end
        end
        S_BUS: begin
          // A ready in the final allowed cycle still completes; abort only when it is absent.
          if (bus_ready) begin
            if (bus_write) begin
              state <= S_IDLE;
            end else begin
              memory_load <= bus_rdata;
              state       <= S_WB;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (fault_set) begin
      fault <= 1'b1;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end
  end

endmodule
